// File: rtl/piece_plot_pkg.sv
// Shared definitions for the Connect4 piece plotter: FSM state encoding,
// object size default, board geometry and a request range check.
package piece_plot_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRAW  = 2'd1,
    FLUSH = 2'd2
  } state_e;

  localparam int OBJ_BITS_DEFAULT   = 3;
  localparam int X_ORIGIN_DEFAULT   = 20;
  localparam int Y_ORIGIN_DEFAULT   = 10;
  localparam int CELL_PITCH_DEFAULT = 10;
  localparam int NCOLS_DEFAULT      = 7;
  localparam int NROWS_DEFAULT      = 6;

  localparam logic [2:0] COLOR_BLACK = 3'b000;

  // True when (c, r) names a real board cell.
  function automatic logic cell_in_range(input logic [2:0] c, input logic [2:0] r,
                                         input int ncols, input int nrows);
    return (int'(c) < ncols) && (int'(r) < nrows);
  endfunction

endpackage

// File: rtl/piece_plot_fsm_if.sv
// Request handshake, object-memory port and VGA plot stream of the piece
// plotter. The slave modport is the plotter; the master modport is the
// game controller plus memories plus VGA sink seen as one peer.
interface piece_plot_fsm_if
  import piece_plot_pkg::*;
#(
  parameter int OBJ_BITS = OBJ_BITS_DEFAULT
);
  logic                  req;
  logic [2:0]            col;
  logic [2:0]            row;
  logic                  player;
  logic                  ready;
  logic                  done;
  logic                  err;
  logic [2*OBJ_BITS-1:0] mem_addr;
  logic [2:0]            mem_q1;
  logic [2:0]            mem_q2;
  logic [7:0]            VGA_X;
  logic [6:0]            VGA_Y;
  logic [2:0]            VGA_COLOR;
  logic                  plot;

  modport master (
    output req, col, row, player, mem_q1, mem_q2,
    input  ready, done, err, mem_addr, VGA_X, VGA_Y, VGA_COLOR, plot
  );

  modport slave (
    input  req, col, row, player, mem_q1, mem_q2,
    output ready, done, err, mem_addr, VGA_X, VGA_Y, VGA_COLOR, plot
  );
endinterface

// File: rtl/piece_plot_fsm_obj_scan_counter.sv
// obj_scan_counter: raster-order {yc,xc} walker over a square object.
// xc advances every enabled cycle; yc advances when xc wraps. last_o flags
// the all-ones position so the caller knows the final address is out.
module obj_scan_counter #(
  parameter int OBJ_BITS = 3
) (
  input  logic                Clock,
  input  logic                Resetn,
  input  logic                clr_i,
  input  logic                en_i,
  output logic [OBJ_BITS-1:0] xc_o,
  output logic [OBJ_BITS-1:0] yc_o,
  output logic                last_o
);

  logic [OBJ_BITS-1:0] xc_q, xc_d;
  logic [OBJ_BITS-1:0] yc_q, yc_d;

  // Next position: clear wins over enable; yc only moves on xc wrap.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    xc_d = xc_q;
    yc_d = yc_q;
    if (clr_i) begin
      xc_d = '0;
      yc_d = '0;
    end else if (en_i) begin
      xc_d = xc_q + 1'b1;
      if (&xc_q) yc_d = yc_q + 1'b1;
    end
  end

  // Position registers, synchronous active-low reset.
  always_ff @(posedge Clock) begin
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (!Resetn) begin
      xc_q <= '0;
      yc_q <= '0;
    end else begin
      xc_q <= xc_d;
      yc_q <= yc_d;
    end
  end

  assign xc_o   = xc_q;
  assign yc_o   = yc_q;
  assign last_o = (&xc_q) & (&yc_q);

endmodule

// File: rtl/piece_plot_fsm.sv
// piece_plot_fsm: accepts one board-cell draw request and streams the 8x8
// piece object to the VGA plot inputs, one pixel per cycle.
// Timing: request accepted at end of T0, address 0 in T1, plot T2..T65,
// done in T65 with the last pixel, ready again from T66.
// Build option: define PIECE_TRANSPARENT_EN to suppress plotting of black
// (3'b000) object pixels; timing and done are unaffected.
module piece_plot_fsm
  import piece_plot_pkg::*;
#(
  parameter int OBJ_BITS   = OBJ_BITS_DEFAULT,
  parameter int X_ORIGIN   = X_ORIGIN_DEFAULT,
  parameter int Y_ORIGIN   = Y_ORIGIN_DEFAULT,
  parameter int CELL_PITCH = CELL_PITCH_DEFAULT,
  parameter int NCOLS      = NCOLS_DEFAULT,
  parameter int NROWS      = NROWS_DEFAULT
) (
  input logic              Clock,
  input logic              Resetn,
  piece_plot_fsm_if.slave  bus
);

  state_e state_q, state_d;

  logic                accept, bad_req;
  logic                cnt_clr, cnt_en, last_pix;
  logic [OBJ_BITS-1:0] xc, yc;

  logic       player_q;
  logic [7:0] x0_q, x0_d, x_q;
  logic [6:0] y0_q, y0_d, y_q;
  logic       valid_q;
  logic       err_q;
  logic [2:0] color_sel;

  obj_scan_counter #(
    .OBJ_BITS (OBJ_BITS)
  ) u_scan (
    .Clock  (Clock),
    .Resetn (Resetn),
    .clr_i  (cnt_clr),
    .en_i   (cnt_en),
    .xc_o   (xc),
    .yc_o   (yc),
    .last_o (last_pix)
  );

  // Cell origin in pixels; row 0 is the bottom board row. Truncated to the
  // VGA coordinate widths, no clipping.
  always_comb begin
    x0_d = 8'(X_ORIGIN + int'(bus.col) * CELL_PITCH);
    y0_d = 7'(Y_ORIGIN + (NROWS - 1 - int'(bus.row)) * CELL_PITCH);
  end

  // Next-state and control decode.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    bad_req = 1'b0;
    cnt_clr = 1'b0;
    cnt_en  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (bus.req) begin
          if (cell_in_range(bus.col, bus.row, NCOLS, NROWS)) begin
            accept  = 1'b1;
            state_d = DRAW;
          end else begin
            bad_req = 1'b1;
          end
        end
      end
      DRAW: begin
        cnt_en = 1'b1;
        if (last_pix) state_d = FLUSH;
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Request latch, err pulse and the coordinate/valid stage that lines up
  // with the one-cycle object memory read.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      player_q <= 1'b0;
      x0_q     <= '0;
      y0_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q   <= bad_req;
      valid_q <= (state_q == DRAW);
      if (accept) begin
        player_q <= bus.player;
        x0_q     <= x0_d;
        y0_q     <= y0_d;
      end
      if (state_q == DRAW) begin
        x_q <= x0_q + 8'(xc);
        y_q <= y0_q + 7'(yc);
      end
    end
  end

  // Colour comes straight from the memory selected by the latched player.
  assign color_sel = player_q ? bus.mem_q1 : bus.mem_q2;

  assign bus.mem_addr  = {yc, xc};
  assign bus.VGA_X     = x_q;
  assign bus.VGA_Y     = y_q;
  assign bus.VGA_COLOR = color_sel;
  assign bus.ready     = (state_q == IDLE);
  assign bus.done      = (state_q == FLUSH);
  assign bus.err       = err_q;

`ifdef PIECE_TRANSPARENT_EN
  assign bus.plot = valid_q && (color_sel != COLOR_BLACK);
`else
  assign bus.plot = valid_q;
`endif

endmodule

// File: tb/tb_piece_plot_fsm.sv
// Self-checking bench for piece_plot_fsm. A cycle-indexed reference model
// derives each expected pixel from the cell geometry and memory contents.
module tb_piece_plot_fsm;

  localparam int X0B   = 20;
  localparam int Y0B   = 10;
  localparam int PITCH = 10;
  localparam int NR    = 6;

  logic Clock;
  logic Resetn;
  int   checks;
  int   errors;

  logic [2:0] mem1 [64];
  logic [2:0] mem2 [64];

  piece_plot_fsm_if bus ();

  piece_plot_fsm dut (
    .Clock  (Clock),
    .Resetn (Resetn),
    .bus    (bus)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Object memories with one-cycle registered read.
  always @(posedge Clock) begin
    bus.mem_q1 <= mem1[bus.mem_addr];
    bus.mem_q2 <= mem2[bus.mem_addr];
  end

  function automatic bit visible(input logic [2:0] c);
`ifdef PIECE_TRANSPARENT_EN
    return c != 3'b000;
`else
    return 1'b1;
`endif
  endfunction

  task automatic fill_random();
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 3'($urandom_range(0, 7));
      mem2[i] = 3'($urandom_range(0, 7));
    end
  endtask

  task automatic fill_index();
    for (int i = 0; i < 64; i++) begin
      mem1[i] = 3'(i);
      mem2[i] = 3'(7 - (i % 8));
    end
  endtask

  task automatic fill_alt();
    for (int i = 0; i < 64; i++) begin
      mem1[i] = (i % 2 == 1) ? 3'd5 : 3'd0;
      mem2[i] = (i % 2 == 1) ? 3'd5 : 3'd0;
    end
  endtask

  // Issue one request and check every cycle T1..T68 against the model.
  task automatic run_draw(input int c_col, input int c_row, input bit c_pl,
                          input bit busy, input string name);
    int       x0, y0, idx, nplots, nexp;
    bit       exp_plot;
    logic [2:0] ecol;
    x0 = X0B + c_col * PITCH;
    y0 = Y0B + (NR - 1 - c_row) * PITCH;
    nplots = 0;
    nexp = 0;
    for (int i = 0; i < 64; i++)
      if (visible(c_pl ? mem1[i] : mem2[i])) nexp++;

    @(negedge Clock);
    bus.req = 1'b1; bus.col = 3'(c_col); bus.row = 3'(c_row); bus.player = c_pl;
    @(negedge Clock);
    bus.req = 1'b0;
    bus.col = 3'($urandom_range(0, 7)); bus.row = 3'($urandom_range(0, 7));
    bus.player = ~c_pl;

    for (int c = 1; c <= 68; c++) begin
      idx = c - 2;
      exp_plot = 1'b0;
      ecol = 3'd0;
      if (c >= 2 && c <= 65) begin
        ecol = c_pl ? mem1[idx] : mem2[idx];
        exp_plot = visible(ecol);
      end
      if (bus.plot === 1'b1) nplots++;

      checks++;
      if (bus.plot !== exp_plot) begin
        errors++;
        $display("FAIL %s plot T%0d: got %b want %b", name, c, bus.plot, exp_plot);
      end
      checks++;
      if (bus.done !== (c == 65)) begin
        errors++;
        $display("FAIL %s done T%0d: got %b want %b", name, c, bus.done, (c == 65));
      end
      checks++;
      if (bus.ready !== (c >= 66)) begin
        errors++;
        $display("FAIL %s ready T%0d: got %b want %b", name, c, bus.ready, (c >= 66));
      end
      checks++;
      if (bus.err !== 1'b0) begin
        errors++;
        $display("FAIL %s err T%0d: got %b want 0", name, c, bus.err);
      end
      if (c <= 64) begin
        checks++;
        if (bus.mem_addr !== 6'(c - 1)) begin
          errors++;
          $display("FAIL %s mem_addr T%0d: got %0d want %0d", name, c, bus.mem_addr, c - 1);
        end
      end
      if (exp_plot) begin
        checks++;
        if (bus.VGA_X !== 8'(x0 + idx % 8) || bus.VGA_Y !== 7'(y0 + idx / 8) ||
            bus.VGA_COLOR !== ecol) begin
          errors++;
          $display("FAIL %s pixel %0d: got (%0d,%0d,c%0d) want (%0d,%0d,c%0d)", name, idx,
                   bus.VGA_X, bus.VGA_Y, bus.VGA_COLOR, x0 + idx % 8, y0 + idx / 8, ecol);
        end
      end

      if (busy && c <= 60) begin
        bus.req = 1'($urandom_range(0, 1));
        bus.col = 3'($urandom_range(0, 7));
        bus.row = 3'($urandom_range(0, 7));
        bus.player = 1'($urandom_range(0, 1));
      end else begin
        bus.req = 1'b0;
      end
      @(negedge Clock);
    end

    checks++;
    if (nplots != nexp) begin
      errors++;
      $display("FAIL %s plot count: got %0d want %0d", name, nplots, nexp);
    end
  endtask

  task automatic test_reset();
    Resetn = 1'b0;
    bus.req = 1'b0; bus.col = '0; bus.row = '0; bus.player = 1'b0;
    repeat (2) @(negedge Clock);
    Resetn = 1'b1;
    checks++;
    if (bus.plot !== 1'b0 || bus.done !== 1'b0 || bus.err !== 1'b0 || bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL reset flags: got plot=%b done=%b err=%b ready=%b want 0 0 0 1",
               bus.plot, bus.done, bus.err, bus.ready);
    end
    checks++;
    if (bus.VGA_X !== 8'd0 || bus.VGA_Y !== 7'd0 || bus.mem_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset coords: got x=%0d y=%0d addr=%0d want 0 0 0",
               bus.VGA_X, bus.VGA_Y, bus.mem_addr);
    end
  endtask

  task automatic test_bottom_left();
    fill_index();
    run_draw(0, 0, 1'b1, 1'b0, "bottom_left");
  endtask

  task automatic test_top_right();
    fill_random();
    run_draw(6, 5, 1'b0, 1'b0, "top_right");
  endtask

  task automatic test_out_of_range();
    int cols [2] = '{7, 0};
    int rows [2] = '{0, 6};
    for (int k = 0; k < 2; k++) begin
      @(negedge Clock);
      bus.req = 1'b1; bus.col = 3'(cols[k]); bus.row = 3'(rows[k]); bus.player = 1'b1;
      @(negedge Clock);
      bus.req = 1'b0;
      for (int c = 1; c <= 3; c++) begin
        checks++;
        if (bus.err !== (c == 1) || bus.plot !== 1'b0 || bus.ready !== 1'b1 ||
            bus.done !== 1'b0) begin
          errors++;
          $display("FAIL out_of_range c%0d r%0d T%0d: got err=%b plot=%b ready=%b done=%b want %b 0 1 0",
                   cols[k], rows[k], c, bus.err, bus.plot, bus.ready, bus.done, (c == 1));
        end
        @(negedge Clock);
      end
    end
  endtask

  task automatic test_busy();
    fill_random();
    run_draw(3, 2, 1'b1, 1'b1, "busy");
  endtask

  task automatic test_mid_reset();
    bit bad;
    fill_random();
    @(negedge Clock);
    bus.req = 1'b1; bus.col = 3'd2; bus.row = 3'd4; bus.player = 1'b0;
    @(negedge Clock);
    bus.req = 1'b0;
    // Now in T1; advance to T31, where the 30th pixel is on the bus.
    repeat (30) @(negedge Clock);
    checks++;
    if (bus.plot !== 1'b1 || bus.VGA_X !== 8'(X0B + 2 * PITCH + 29 % 8)) begin
      errors++;
      $display("FAIL mid_reset 30th plot: got plot=%b x=%0d want 1 %0d",
               bus.plot, bus.VGA_X, X0B + 2 * PITCH + 29 % 8);
    end
    Resetn = 1'b0;
    @(negedge Clock);
    checks++;
    if (bus.plot !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1 ||
        bus.VGA_X !== 8'd0 || bus.VGA_Y !== 7'd0) begin
      errors++;
      $display("FAIL mid_reset after: got plot=%b done=%b ready=%b x=%0d y=%0d want 0 0 1 0 0",
               bus.plot, bus.done, bus.ready, bus.VGA_X, bus.VGA_Y);
    end
    Resetn = 1'b1;
    bad = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(negedge Clock);
      if (bus.plot !== 1'b0 || bus.done !== 1'b0 || bus.ready !== 1'b1) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      errors++;
      $display("FAIL mid_reset abandoned: got activity after reset want idle");
    end
    run_draw(1, 1, 1'b1, 1'b0, "after_reset");
  endtask

  task automatic test_random();
    for (int n = 0; n < 5; n++) begin
      fill_random();
      run_draw($urandom_range(0, 6), $urandom_range(0, 5), 1'($urandom_range(0, 1)),
               1'b0, "random");
    end
  endtask

  task automatic test_back_to_back();
    fill_random();
    run_draw(4, 3, 1'b0, 1'b0, "b2b_first");
    run_draw(5, 1, 1'b1, 1'b0, "b2b_second");
  endtask

  task automatic test_transparent();
    fill_alt();
    run_draw(2, 3, 1'b1, 1'b0, "alt_p1");
    run_draw(5, 0, 1'b0, 1'b0, "alt_p2");
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_bottom_left();
    test_top_right();
    test_out_of_range();
    test_busy();
    test_mid_reset();
    test_random();
    test_back_to_back();
    test_transparent();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
